// File: rtl/ram_dp.sv
// Simple dual-port synchronous RAM with byte-lane write masks, selectable read
// latency and read-during-write policy, and a post-reset clear engine.
module ram_dp #(
  parameter int unsigned AW       = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned BW       = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WR_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW/BW-1:0]    wr_mask,
  input  logic [DW-1:0]       data_in,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int unsigned NL = DW / BW;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem_q [2**AW];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   wr_merged;
  logic [DW-1:0]   rd_word;
  logic            rd_accept;

  logic            pipe_valid_q, pipe_valid_d;
  logic [DW-1:0]   pipe_data_q, pipe_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   data_out_q, data_out_d;

  // Merged word is built from the current contents so a full-word write
  // implements the lane mask; it doubles as the write-first collision result.
  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int unsigned i = 0; i < NL; i++) begin
      if (wr_mask[i]) begin
        wr_merged[i*BW +: BW] = data_in[i*BW +: BW];
      end
    end
    if ((WR_FIRST != 0) && wr_en && (rd_addr == wr_addr)) begin
      rd_word = wr_merged;
    end else begin
      rd_word = mem_q[rd_addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    rd_accept = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = !reset;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        mem_we    = !reset && wr_en && (|wr_mask);
        rd_accept = !reset && rd_en;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    pipe_valid_d = rd_accept;
    pipe_data_d  = rd_accept ? rd_word : pipe_data_q;
    if (RD_LAT == 1) begin
      rd_valid_d = rd_accept;
      data_out_d = rd_accept ? rd_word : data_out_q;
    end else begin
      rd_valid_d = pipe_valid_q;
      data_out_d = pipe_valid_q ? pipe_data_q : data_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      rd_valid_q   <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      rd_valid_q   <= rd_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: two instances (write-first/latency 1 and read-first/latency 2)
// share stimulus and are checked against a word-level reference model.
module tb_ram_dp;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_mask;
  logic [7:0] data_in;
  logic       rd_en;
  logic [2:0] rd_addr;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_busy, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_mem [8];
  int         clear_left = 8;
  int         clear_idx  = 0;
  logic       exp_busy   = 1'b1;
  logic       ea_v = 1'b0, eb_v = 1'b0, pb_v = 1'b0;
  logic [7:0] ea_d = 8'h00, eb_d = 8'h00, pb_d = 8'h00;

  ram_dp #(.AW(3), .DW(8), .BW(4), .RD_LAT(1), .WR_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .data_out(a_data), .rd_valid(a_valid), .busy(a_busy)
  );

  ram_dp #(.AW(3), .DW(8), .BW(4), .RD_LAT(2), .WR_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .data_out(b_data), .rd_valid(b_valid), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_merge(input logic [7:0] old, input logic [7:0] din,
                                            input logic [1:0] mask);
    logic [7:0] r;
    r = old;
    if (mask[0]) r[3:0] = din[3:0];
    if (mask[1]) r[7:4] = din[7:4];
    return r;
  endfunction

  task automatic model_edge();
    logic       ready;
    logic [7:0] old_w, new_w;
    if (reset) begin
      clear_left = 8; clear_idx = 0;
      ea_v = 1'b0; ea_d = 8'h00; eb_v = 1'b0; eb_d = 8'h00; pb_v = 1'b0; pb_d = 8'h00;
    end else begin
      ready = (clear_left == 0);
      old_w = m_mem[rd_addr];
      new_w = lane_merge(m_mem[wr_addr], data_in, wr_mask);
      eb_v = pb_v;
      if (pb_v) eb_d = pb_d;
      pb_v = ready && rd_en;
      if (pb_v) pb_d = old_w;
      ea_v = ready && rd_en;
      if (ea_v) ea_d = (wr_en && wr_addr == rd_addr) ? new_w : old_w;
      if (ready && wr_en) m_mem[wr_addr] = new_w;
      if (!ready) begin
        m_mem[clear_idx] = 8'h00;
        clear_idx++;
        clear_left--;
      end
    end
    exp_busy = (clear_left > 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy_a",  a_busy,  exp_busy);
    check("busy_b",  b_busy,  exp_busy);
    check("valid_a", a_valid, ea_v);
    check("data_a",  a_data,  ea_d);
    check("valid_b", b_valid, eb_v);
    check("data_b",  b_data,  eb_d);
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 3'd0; wr_mask = 2'b00; data_in = 8'h00; rd_addr = 3'd0;
  endtask

  task automatic drive_wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] m);
    wr_en = 1'b1; wr_addr = a; data_in = d; wr_mask = m;
  endtask

  task automatic drive_rd(input logic [2:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_busy",  a_busy,  1'b1);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data",  a_data,  8'h00);

    // clear: requests during busy are ignored
    idle();
    for (int k = 1; k <= 8; k++) begin
      drive_wr(3'd0, 8'hFF, 2'b11);
      drive_rd(3'd0);
      step();
      check("clear_busy",  a_busy,  (k < 8) ? 1'b1 : 1'b0);
      check("clear_valid", a_valid, 1'b0);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      drive_rd(i[2:0]);
      step();
      check("clr_rd_valid", a_valid, 1'b1);
      check("clr_rd_data",  a_data,  8'h00);
    end
    idle();
    step();
    step();

    // masked write then latency check
    drive_wr(3'd2, 8'hAB, 2'b11); step();
    drive_wr(3'd2, 8'h5C, 2'b01); step();
    idle(); drive_rd(3'd2); step();
    check("lat1_valid", a_valid, 1'b1);
    check("lat1_data",  a_data,  8'hAC);
    check("lat2_early", b_valid, 1'b0);
    idle(); step();
    check("lat1_pulse", a_valid, 1'b0);
    check("lat1_hold",  a_data,  8'hAC);
    check("lat2_valid", b_valid, 1'b1);
    check("lat2_data",  b_data,  8'hAC);
    step();
    check("lat2_pulse", b_valid, 1'b0);
    check("lat2_hold",  b_data,  8'hAC);

    // collision
    drive_wr(3'd5, 8'h11, 2'b11); step();
    idle(); drive_wr(3'd5, 8'hF0, 2'b10); drive_rd(3'd5); step();
    check("coll_wf", a_data, 8'hF1);
    idle(); drive_rd(3'd5); step();
    check("coll_after_a", a_data, 8'hF1);
    check("coll_rf",      b_data, 8'h11);
    idle(); step();
    check("coll_after_b", b_data, 8'hF1);

    // streaming
    for (int i = 0; i < 8; i++) begin
      idle(); drive_wr(i[2:0], 8'h10 + 8'(i), 2'b11); step();
    end
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 8) drive_rd(i[2:0]);
      step();
      if (i < 8) begin
        check("stream_a_valid", a_valid, 1'b1);
        check("stream_a_data",  a_data,  8'h10 + 8'(i));
      end
      if (i > 0) begin
        check("stream_b_valid", b_valid, 1'b1);
        check("stream_b_data",  b_data,  8'h10 + 8'(i - 1));
      end
    end
    idle(); step();

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 63) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 3'($urandom_range(0, 7));
      wr_mask = 2'($urandom_range(0, 3));
      data_in = 8'($urandom);
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      step();
    end
    idle();
    for (int n = 0; n < 10; n++) step();

    // reset mid-clear after nonzero preload; in-flight latency-2 read discarded
    for (int i = 0; i < 8; i++) begin
      idle(); drive_wr(i[2:0], 8'hA0 + 8'(i), 2'b11); step();
    end
    idle(); drive_rd(3'd3); step();
    idle(); reset = 1'b1; step();
    check("rst_inflight_b", b_valid, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1; step();
    idle();
    for (int k = 1; k <= 8; k++) begin
      step();
      check("reclear_busy", a_busy, (k < 8) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      idle(); drive_rd(i[2:0]); step();
      check("reclear_data", a_data, 8'h00);
    end
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
